// File: rtl/round_pkg.sv
// round_pkg: rounding-mode encoding shared by round_sat_stream and round_lane.
// Contents:
//   round_mode_t   2-bit rounding mode carried with each beat
//   ROUND_*        mode constants (trunc/floor, half-up, half-even, toward zero)
package round_pkg;

    typedef logic [1:0] round_mode_t;

    localparam round_mode_t ROUND_TRUNC     = 2'd0;
    localparam round_mode_t ROUND_HALF_UP   = 2'd1;
    localparam round_mode_t ROUND_HALF_EVEN = 2'd2;
    localparam round_mode_t ROUND_TO_ZERO   = 2'd3;

endpackage

// File: rtl/round_lane.sv
// round_lane: combinational single-lane rounder; picks the increment for the selected
// mode and adds it to the sign-extended integer part.
// Ports:
//   int_i   N_Integer   two's-complement integer part
//   frac_i  N_Fraction  fraction bits
//   mode_i  2           rounding mode
//   sum_o   N_Integer+1 sign-extended integer plus increment
//   ovf_o   1           top two sum bits differ (result does not fit N_Integer bits)
module round_lane
    import round_pkg::*;
#(
    parameter int N_Integer  = 8,
    parameter int N_Fraction = 8
) (
    input  logic [N_Integer-1:0]  int_i,
    input  logic [N_Fraction-1:0] frac_i,
    input  round_mode_t           mode_i,
    output logic [N_Integer:0]    sum_o,
    output logic                  ovf_o
);

    logic a, b, c, s, inc;

    assign a = int_i[0];
    assign b = frac_i[N_Fraction-1];
    assign c = |frac_i[N_Fraction-2:0];
    assign s = int_i[N_Integer-1];

    always_comb begin
        inc = mode_i == ROUND_TRUNC     ? 1'b0 :
              mode_i == ROUND_HALF_UP   ? b :
              mode_i == ROUND_HALF_EVEN ? b & (a | c) :
              mode_i == ROUND_TO_ZERO   ? s & (b | c) : 1'b0;
        sum_o = {s, int_i} + {{N_Integer{1'b0}}, inc};
        ovf_o = sum_o[N_Integer] ^ sum_o[N_Integer-1];
    end

endmodule

// File: rtl/round_sat_stream.sv
// round_sat_stream: multi-lane streaming fixed-point rounder with saturation, 2-stage
// valid/ready pipeline and sticky saturation flag.
// Optional feature macro: ROUND_SAT_COUNT_EN adds the N_Count parameter and SatCount port.
// Ports:
//   Clk        clock, rising edge
//   nReset     asynchronous active-low reset
//   InValid    input beat valid
//   InReady    block accepts a beat this cycle
//   InMode     rounding mode, sampled with the beat
//   Integer    lane k integer part at [k*N_Integer +: N_Integer]
//   Fraction   lane k fraction at [k*N_Fraction +: N_Fraction]
//   OutValid   output beat valid
//   OutReady   downstream accepts
//   Output     rounded, saturated lanes
//   OutSat     per-lane clamp flags, qualified by OutValid
//   SatSticky  any lane clamped on a delivered beat since last clear
//   SatClear   synchronous clear of SatSticky (and SatCount)
//   SatCount   saturating count of delivered beats with any clamp (ROUND_SAT_COUNT_EN only)
module round_sat_stream
    import round_pkg::*;
#(
    parameter int N_Integer  = 8,
    parameter int N_Fraction = 8,
    parameter int N_Channels = 4
`ifdef ROUND_SAT_COUNT_EN
    ,parameter int N_Count   = 16
`endif
) (
    input  logic                             Clk,
    input  logic                             nReset,
    input  logic                             InValid,
    output logic                             InReady,
    input  round_mode_t                      InMode,
    input  logic [N_Channels*N_Integer-1:0]  Integer,
    input  logic [N_Channels*N_Fraction-1:0] Fraction,
    output logic                             OutValid,
    input  logic                             OutReady,
    output logic [N_Channels*N_Integer-1:0]  Output,
    output logic [N_Channels-1:0]            OutSat,
    output logic                             SatSticky,
    input  logic                             SatClear
`ifdef ROUND_SAT_COUNT_EN
    ,output logic [N_Count-1:0]              SatCount
`endif
);

    logic                                v1_q, v2_q, sticky_q, load2, sat_hs;
    logic [N_Channels-1:0][N_Integer:0]  lane_sum, sum1_q;
    logic [N_Channels-1:0]               lane_ovf, ovf1_q, sat_q;
    logic [N_Channels*N_Integer-1:0]     out_d, out_q;

    assign load2     = !v2_q | OutReady;
    assign InReady   = !v1_q | load2;
    assign OutValid  = v2_q;
    assign Output    = out_q;
    assign OutSat    = sat_q;
    assign SatSticky = sticky_q;
    assign sat_hs    = v2_q & OutReady & (|sat_q);

    for (genvar k = 0; k < N_Channels; k++) begin : g_lane
        round_lane #(
            .N_Integer  (N_Integer),
            .N_Fraction (N_Fraction)
        ) u_lane (
            .int_i  (Integer[k*N_Integer +: N_Integer]),
            .frac_i (Fraction[k*N_Fraction +: N_Fraction]),
            .mode_i (InMode),
            .sum_o  (lane_sum[k]),
            .ovf_o  (lane_ovf[k])
        );
        // Sum top bit picks the clamp direction; only the positive clamp is reachable.
        assign out_d[k*N_Integer +: N_Integer] = !ovf1_q[k] ? sum1_q[k][N_Integer-1:0] :
            sum1_q[k][N_Integer] ? {1'b1, {(N_Integer-1){1'b0}}} : {1'b0, {(N_Integer-1){1'b1}}};
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            sum1_q   <= '0;
            ovf1_q   <= '0;
            out_q    <= '0;
            sat_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (InReady) begin
                v1_q <= InValid;
                if (InValid) begin
                    sum1_q <= lane_sum;
                    ovf1_q <= lane_ovf;
                end
            end
            if (load2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    out_q <= out_d;
                    sat_q <= ovf1_q;
                end
            end
            sticky_q <= sat_hs | (sticky_q & !SatClear);
        end
    end

`ifdef ROUND_SAT_COUNT_EN
    logic [N_Count-1:0] cnt_q;

    assign SatCount = cnt_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) cnt_q <= '0;
        else         cnt_q <= SatClear ? '0 : (sat_hs && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end
`endif

endmodule

// File: tb/tb_round_sat_stream.sv
// tb_round_sat_stream: directed checks plus a scoreboard driven by an arithmetic rounding model.
module tb_round_sat_stream;

    localparam int NC = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] int_in = '0, frac_in = '0, dout;
    logic [3:0]  sat;
    logic        sticky, sat_clear = 1'b0;
`ifdef ROUND_SAT_COUNT_EN
    logic [1:0]  sat_count;
`endif

    int checks = 0, errors = 0, n_out = 0;

    typedef struct {
        logic [31:0] o;
        logic [3:0]  s;
    } beat_t;
    beat_t q[$];

    always #5 clk = ~clk;

    round_sat_stream #(
        .N_Integer  (8),
        .N_Fraction (8),
        .N_Channels (NC)
`ifdef ROUND_SAT_COUNT_EN
        ,.N_Count   (2)
`endif
    ) dut (
        .Clk       (clk),
        .nReset    (rst_n),
        .InValid   (in_valid),
        .InReady   (in_ready),
        .InMode    (mode),
        .Integer   (int_in),
        .Fraction  (frac_in),
        .OutValid  (out_valid),
        .OutReady  (out_ready),
        .Output    (dout),
        .OutSat    (sat),
        .SatSticky (sticky),
        .SatClear  (sat_clear)
`ifdef ROUND_SAT_COUNT_EN
        ,.SatCount (sat_count)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Value is i + f/256; round by the mode's arithmetic rule, then clamp to [-128,127].
    function automatic logic [7:0] model(input logic [1:0] m, input logic [7:0] i,
                                         input logic [7:0] f, output logic s);
        int x = $signed({i, f});
        int fl = x >>> 8;
        int rem = x - fl * 256;
        int r;
        case (m)
            2'd0:    r = fl;
            2'd1:    r = rem >= 128 ? fl + 1 : fl;
            2'd2:    r = rem > 128 ? fl + 1 : rem < 128 ? fl : fl + (fl & 1);
            default: r = (x < 0 && rem != 0) ? fl + 1 : fl;
        endcase
        s = r > 127 || r < -128;
        r = r > 127 ? 127 : r < -128 ? -128 : r;
        return r[7:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    beat_t e;
                    e = q.pop_front();
                    chk("model_out", dout, e.o);
                    chk("model_sat", sat, e.s);
                end
            end
            if (in_valid && in_ready) begin
                beat_t e;
                logic sb;
                for (int j = 0; j < NC; j++) begin
                    e.o[j*8 +: 8] = model(mode, int_in[j*8 +: 8], frac_in[j*8 +: 8], sb);
                    e.s[j] = sb;
                end
                q.push_back(e);
            end
        end
    end

    task automatic send_one(input logic [1:0] m, input logic [7:0] i, input logic [7:0] f,
                            input logic [7:0] e, input logic es, input string nm);
        @(posedge clk); #1;
        in_valid = 1'b1; mode = m; int_in = {NC{i}}; frac_in = {NC{f}}; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({nm, "_lat1"}, out_valid, 0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_out"}, dout, {NC{e}});
        chk({nm, "_sat"}, sat, {NC{es}});
    endtask

    task automatic ramp(input int k);
        mode = k[1:0];
        for (int j = 0; j < NC; j++) begin
            int_in[j*8 +: 8]  = 8'(k * 53 + j * 71);
            frac_in[j*8 +: 8] = 8'(k * 97 + j * 31);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n0;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_out", dout, 0);
        chk("rst_sat", sat, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1'b1;

        send_one(0, 8'h02, 8'h80, 8'h02, 0, "p25_trunc");
        send_one(1, 8'h02, 8'h80, 8'h03, 0, "p25_halfup");
        send_one(2, 8'h02, 8'h80, 8'h02, 0, "p25_halfeven");
        send_one(3, 8'h02, 8'h80, 8'h02, 0, "p25_tozero");
        send_one(0, 8'hFD, 8'h80, 8'hFD, 0, "m25_trunc");
        send_one(1, 8'hFD, 8'h80, 8'hFE, 0, "m25_halfup");
        send_one(2, 8'hFD, 8'h80, 8'hFE, 0, "m25_halfeven");
        send_one(3, 8'hFD, 8'h80, 8'hFE, 0, "m25_tozero");
        send_one(2, 8'h03, 8'h80, 8'h04, 0, "p35_halfeven");
        send_one(3, 8'h80, 8'h01, 8'h81, 0, "min_tozero");
        @(posedge clk); #1;
        chk("nosat_sticky", sticky, 0);

        send_one(1, 8'h7F, 8'hC0, 8'h7F, 1, "sat");
        @(posedge clk); #1;
        chk("sticky_set", sticky, 1);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("sticky_clr", sticky, 0);

        // Stall: downstream blocked for three cycles while input stays valid.
        n0 = n_out;
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1; ramp(0);
        for (int c = 0; c < 100 && acc < 10; c++) begin
            logic took;
            @(negedge clk);
            took = in_valid && in_ready;
            if (c == 2) begin
                chk("stall_ready", in_ready, 0);
                chk("stall_acc", acc, 2);
            end
            @(posedge clk); #1;
            if (took) acc++;
            out_ready = c >= 2;
            ramp(acc);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("ramp_drain", q.size(), 0);
        chk("ramp_count", n_out - n0, 10);

        // Random valid/ready traffic against the model.
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            in_valid  = $urandom_range(0, 1);
            out_ready = $urandom_range(0, 3) != 0;
            mode      = 2'($urandom_range(0, 3));
            int_in    = $urandom;
            frac_in   = $urandom;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) @(posedge clk);
        #1;
        chk("rand_drain", q.size(), 0);

        // Reset with both stages full.
        send_one(1, 8'h7F, 8'hC0, 8'h7F, 1, "presat");
        out_ready = 1'b0; in_valid = 1'b1; ramp(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_ready", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_sticky", sticky, 0);
        q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        send_one(1, 8'h02, 8'h80, 8'h03, 0, "post_rst");
        @(posedge clk); #1;
        chk("post_rst_drain", out_valid, 0);

`ifdef ROUND_SAT_COUNT_EN
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            send_one(1, 8'h7F, 8'hC0, 8'h7F, 1, "cnt_beat");
            @(posedge clk); #1;
            chk("sat_count", sat_count, n > 3 ? 3 : n);
        end
        send_one(1, 8'h7F, 8'hC0, 8'h7F, 1, "cnt_clr_beat");
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("cnt_clear_wins", sat_count, 0);
        chk("sticky_set_wins", sticky, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
